mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the data-RAM interface: turns load/store requests from the MIPS MEM stage into
//  word-wide RAM cycles (mem_write/addr/write_data/read_data). Adds sub-word stores via read-modify-write,
//  sub-word loads with sign/zero extension, and alignment checks. Sits between the MEM stage and RAM.
// PARAMETERS
//  ADDR_WIDTH  10  byte-address width; must match the RAM ADDR_WIDTH
//  DATA_WIDTH  32  word width; only 32 is supported
// PORTS
//  clk         in   1           system clock, rising edge
//  rst_n       in   1           asynchronous active-low reset
//  req_valid   in   1           request present
//  req_ready   out  1           unit can accept; = (state==IDLE)
//  req_write   in   1           1=store, 0=load
//  req_size    in   2           00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1           loads only: 1 sign-extend, 0 zero-extend
//  req_addr    in   ADDR_WIDTH  byte address
//  req_wdata   in   32          store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid   out  1           one-cycle completion pulse
//  rsp_rdata   out  32          load result, extended; 0 for stores and errors
//  rsp_err     out  1           misaligned or illegal-size request; valid with rsp_valid
//  mem_write   out  1           RAM write enable (registered)
//  mem_addr    out  ADDR_WIDTH  RAM byte address, always {req_addr[AW-1:2],2'b00} (registered)
//  mem_wdata   out  32          RAM write data (registered)
//  mem_rdata   in   32          RAM read data, combinational from mem_addr
// BEHAVIOUR
//  - Reset: state=IDLE; mem_write=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//    req_ready=1 once rst_n is high. Reset mid-operation aborts immediately. mem_write clears
//    asynchronously, so no partial write commits. No response is issued for the aborted request.
//  - Accept on clk edge with req_valid&&req_ready. All req_* fields are latched. Inputs are ignored while busy.
//  - Little-endian lanes: byte offset k = req_addr[1:0] maps to bits [8k+7:8k]. Half offset 0 maps to [15:0],
//    offset 2 maps to [31:16].
//  - Error: size 11, half with addr[0]=1, or word with addr[1:0]!=0. Goes IDLE->RESP with no RAM access.
//    Response: rsp_err=1, rsp_rdata=0.
//  - FSM states: IDLE, READ, WRITE, RESP.
//    IDLE --accept, error--------------> RESP
//    IDLE --accept, load or sub-word st-> READ
//    IDLE --accept, word store---------> WRITE
//    READ --load-----------------------> RESP
//    READ --sub-word store-------------> WRITE
//    WRITE ----------------------------> RESP
//    RESP ------------------------------> IDLE
//  - READ: mem_addr is driven and mem_rdata is captured at the end of the cycle. For loads, the selected lane
//    is extended into rsp_rdata. For stores, the captured word is merged with the store lane into mem_wdata.
//  - WRITE: mem_write=1 for exactly one cycle, with mem_wdata = merged word (or req_wdata for a word store).
//  - RESP: rsp_valid=1 for exactly one cycle. There is no backpressure; the consumer must take it.
//  - Latency from the accept edge to the rsp_valid cycle:
//    load = 2 cycles; word store = 2; sub-word store = 3; error = 1.
//    Back-to-back throughput: one request per (latency+1) cycles.
//  - mem_write is 0 in every state except WRITE. mem_addr holds its last value in IDLE.
//  - Top address (all ones, word-aligned) is legal. No wrap occurs because the address is never incremented.
// TESTING
//  1. Word store 0xDEADBEEF @0x000, then word load @0x000 -> rsp_rdata=DEADBEEF, rsp_err=0, latency 2 each.
//  2. Byte store 0x5A @0x005 over word 0xCAFEBABE @0x004 -> RAM @0x004=CAFE5ABE.
//     Signed byte load @0x005 -> 0000005A. Signed byte load @0x007 -> FFFFFFCA. Unsigned @0x007 -> 000000CA.
//  3. Half store 0x1234 @0x006 over 0xCAFEBABE -> 1234BABE; half signed load @0x004 -> FFFFBABE, exactly
//     one mem_write pulse observed.
//  4. Word load @0x002 and half store @0x001 -> rsp_err=1 one cycle after accept, rsp_rdata=0, no mem_write,
//     RAM unchanged.
//  5. rst_n low during the READ state of a byte store -> outputs zero immediately, no mem_write, no rsp_valid,
//     RAM unchanged. The next request works normally.
//  6. Hold req_valid high with alternating load/store stream -> req_ready low while busy, each request
//     accepted exactly once, responses in order.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bundle between the MEM stage, the memory access unit and the data RAM.
// Signals:
//   req_*  : load/store request from the MEM stage (valid/ready handshake)
//   rsp_*  : one-cycle completion pulse with load data and error flag
//   mem_*  : word-wide RAM port (registered write/addr/wdata, combinational rdata)
// Modports:
//   master : MEM stage plus RAM side; drives requests and mem_rdata
//   slave  : the access unit; accepts requests and drives the RAM cycle
interface mem_access_unit_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Initiator side of the data-RAM interface. Turns MEM-stage load/store requests into word-wide
// RAM cycles: sub-word stores by read-modify-write, sub-word loads with sign/zero extension,
// and alignment/size checks that answer with an error and touch no RAM.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/response handshake and RAM port (mem_access_unit_if.slave)
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [1:0]            off_q, off_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic        accept;
    logic        req_bad;
    logic [4:0]  lane_shift;
    logic [31:0] rd_shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] byte_mask;
    logic [31:0] merged;

    assign accept = bus.req_valid && (state_q == StIdle);

    // Size 11, odd half address, or word not on a word boundary.
    assign req_bad = (bus.req_size == 2'b11) ||
                     ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    // Little-endian lanes: byte offset k lives in bits [8k+7:8k].
    assign lane_shift = {off_q, 3'b000};
    assign rd_shifted = bus.mem_rdata >> lane_shift;
    assign byte_sel   = rd_shifted[7:0];
    assign half_sel   = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    assign byte_mask  = 32'h0000_00ff << lane_shift;

    always_comb begin
        unique case (size_q)
            2'b00:   load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_val = bus.mem_rdata;
        endcase
    end

    always_comb begin
        if (size_q == 2'b00) begin
            merged = (bus.mem_rdata & ~byte_mask) | ({24'h0, wdata_q[7:0]} << lane_shift);
        end else if (off_q[1]) begin
            merged = {wdata_q[15:0], bus.mem_rdata[15:0]};
        end else begin
            merged = {bus.mem_rdata[31:16], wdata_q[15:0]};
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // Pulse-style outputs default low so each is high only in its own state.
        mem_write_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    write_d  = bus.req_write;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    off_d    = bus.req_addr[1:0];
                    wdata_d  = bus.req_wdata;
                    if (req_bad) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        state_d     = StResp;
                    end else begin
                        mem_addr_d = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (bus.req_write && (bus.req_size == 2'b10)) begin
                            mem_write_d = 1'b1;
                            mem_wdata_d = bus.req_wdata;
                            state_d     = StWrite;
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
            end
            StRead: begin
                if (write_q) begin
                    mem_wdata_d = merged;
                    mem_write_d = 1'b1;
                    state_d     = StWrite;
                end else begin
                    rsp_rdata_d = load_val;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StWrite: begin
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Async clear of mem_write guarantees an aborted store never commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= 32'h0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word RAM.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] ram [0:255];

    mem_access_unit_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    mem_access_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_write === 1'b1) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = ram[bus.mem_addr[9:2]];

    // Issues one request and waits (bounded) for its response pulse.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [9:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int wr_cnt, output bit seen);
        rd = 32'hx; er = 1'bx; lat = 0; wr_cnt = 0; seen = 0;
        @(negedge clk);
        bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.mem_write === 1'b1) wr_cnt++;
            if (bus.rsp_valid === 1'b1) begin
                seen = 1; rd = bus.rsp_rdata; er = bus.rsp_err;
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", bus.mem_write); end
        checks++; if (bus.mem_addr !== 10'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 000", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; int wc; bit seen;
        do_req(1'b1, 2'b10, 1'b0, 10'h000, 32'hDEADBEEF, rd, er, lat, wc, seen);
        checks++; if (!seen || lat != 2) begin errors++; $display("FAIL word_store_lat: got %0d (seen %0d) want 2", lat, seen); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL word_store_rsp: got err %b data %h want 0/0", er, rd); end
        checks++; if (wc != 1) begin errors++; $display("FAIL word_store_writes: got %0d want 1", wc); end
        checks++; if (ram[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_store_ram: got %h want deadbeef", ram[0]); end
        do_req(1'b0, 2'b10, 1'b0, 10'h000, 32'h0, rd, er, lat, wc, seen);
        checks++; if (!seen || lat != 2) begin errors++; $display("FAIL word_load_lat: got %0d want 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL word_load_data: got %h err %b want deadbeef/0", rd, er); end
        checks++; if (wc != 0) begin errors++; $display("FAIL word_load_writes: got %0d want 0", wc); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat; int wc; bit seen;
        do_req(1'b1, 2'b10, 1'b0, 10'h004, 32'hCAFEBABE, rd, er, lat, wc, seen);
        do_req(1'b1, 2'b00, 1'b0, 10'h005, 32'h0000005A, rd, er, lat, wc, seen);
        checks++; if (!seen || lat != 3) begin errors++; $display("FAIL byte_store_lat: got %0d want 3", lat); end
        checks++; if (wc != 1) begin errors++; $display("FAIL byte_store_writes: got %0d want 1", wc); end
        checks++; if (ram[1] !== 32'hCAFE5ABE) begin errors++; $display("FAIL byte_store_ram: got %h want cafe5abe", ram[1]); end
        do_req(1'b0, 2'b00, 1'b1, 10'h005, 32'h0, rd, er, lat, wc, seen);
        checks++; if (rd !== 32'h0000005A || lat != 2) begin errors++; $display("FAIL byte_load_s5: got %h lat %0d want 0000005a lat 2", rd, lat); end
        do_req(1'b0, 2'b00, 1'b1, 10'h007, 32'h0, rd, er, lat, wc, seen);
        checks++; if (rd !== 32'hFFFFFFCA) begin errors++; $display("FAIL byte_load_s7: got %h want ffffffca", rd); end
        do_req(1'b0, 2'b00, 1'b0, 10'h007, 32'h0, rd, er, lat, wc, seen);
        checks++; if (rd !== 32'h000000CA) begin errors++; $display("FAIL byte_load_u7: got %h want 000000ca", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat; int wc; bit seen;
        do_req(1'b1, 2'b10, 1'b0, 10'h004, 32'hCAFEBABE, rd, er, lat, wc, seen);
        do_req(1'b1, 2'b01, 1'b0, 10'h006, 32'h00001234, rd, er, lat, wc, seen);
        checks++; if (wc != 1 || lat != 3) begin errors++; $display("FAIL half_store_cycle: got writes %0d lat %0d want 1/3", wc, lat); end
        checks++; if (ram[1] !== 32'h1234BABE) begin errors++; $display("FAIL half_store_ram: got %h want 1234babe", ram[1]); end
        do_req(1'b0, 2'b01, 1'b1, 10'h004, 32'h0, rd, er, lat, wc, seen);
        checks++; if (rd !== 32'hFFFFBABE) begin errors++; $display("FAIL half_load_s4: got %h want ffffbabe", rd); end
        do_req(1'b0, 2'b01, 1'b0, 10'h006, 32'h0, rd, er, lat, wc, seen);
        checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL half_load_u6: got %h want 00001234", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; int wc; bit seen;
        do_req(1'b0, 2'b10, 1'b0, 10'h002, 32'h0, rd, er, lat, wc, seen);
        checks++; if (!seen || lat != 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_word_load: got lat %0d err %b data %h want 1/1/0", lat, er, rd); end
        checks++; if (wc != 0) begin errors++; $display("FAIL err_word_load_writes: got %0d want 0", wc); end
        do_req(1'b1, 2'b01, 1'b0, 10'h001, 32'h0000FFFF, rd, er, lat, wc, seen);
        checks++; if (!seen || lat != 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_half_store: got lat %0d err %b data %h want 1/1/0", lat, er, rd); end
        checks++; if (wc != 0 || ram[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL err_half_store_ram: got writes %0d ram %h want 0/deadbeef", wc, ram[0]); end
        do_req(1'b1, 2'b11, 1'b0, 10'h000, 32'h12345678, rd, er, lat, wc, seen);
        checks++; if (er !== 1'b1 || wc != 0 || ram[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL err_size11: got err %b writes %0d ram %h want 1/0/deadbeef", er, wc, ram[0]); end
        do_req(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0, rd, er, lat, wc, seen);
        checks++; if (!seen || er !== 1'b0 || lat != 2) begin errors++; $display("FAIL top_addr_load: got err %b lat %0d want 0/2", er, lat); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; int wc; bit seen;
        int bad = 0;
        @(negedge clk);
        bus.req_write = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 10'h005; bus.req_wdata = 32'h00000077; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_write !== 1'b0 || bus.mem_addr !== 10'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL abort_outputs: got we %b addr %h wdata %h want 0/0/0", bus.mem_write, bus.mem_addr, bus.mem_wdata); end
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.mem_write !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.mem_write !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_no_pulse: got %0d bad cycles want 0", bad); end
        checks++; if (ram[1] !== 32'h1234BABE) begin errors++; $display("FAIL abort_ram: got %h want 1234babe", ram[1]); end
        do_req(1'b0, 2'b10, 1'b0, 10'h004, 32'h0, rd, er, lat, wc, seen);
        checks++; if (rd !== 32'h1234BABE || lat != 2) begin errors++; $display("FAIL abort_recover: got %h lat %0d want 1234babe lat 2", rd, lat); end
    endtask

    task automatic test_back_to_back();
        logic        wr_t [4];
        logic [9:0]  ad_t [4];
        logic [31:0] wd_t [4];
        logic [31:0] rsp_t [4];
        int idx = 0; int acc = 0; int nrsp = 0; int low = 0;
        wr_t = '{1'b1, 1'b0, 1'b1, 1'b0};
        ad_t = '{10'h010, 10'h010, 10'h014, 10'h014};
        wd_t = '{32'h11111111, 32'hFFFFFFFF, 32'h22222222, 32'hFFFFFFFF};
        rsp_t = '{32'hx, 32'hx, 32'hx, 32'hx};
        for (int c = 0; c < 40 && nrsp < 4; c++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                if (nrsp < 4) rsp_t[nrsp] = bus.rsp_rdata;
                nrsp++;
            end
            if (idx < 4) begin
                bus.req_write = wr_t[idx]; bus.req_size = 2'b10; bus.req_signed = 1'b0;
                bus.req_addr = ad_t[idx]; bus.req_wdata = wd_t[idx]; bus.req_valid = 1'b1;
                if (bus.req_ready === 1'b1) begin acc++; idx++; end
                else low++;
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        checks++; if (acc != 4 || nrsp != 4) begin errors++; $display("FAIL b2b_counts: got acc %0d rsp %0d want 4/4", acc, nrsp); end
        checks++; if (low != 6) begin errors++; $display("FAIL b2b_ready_low: got %0d want 6", low); end
        checks++; if (rsp_t[0] !== 32'h0 || rsp_t[1] !== 32'h11111111) begin errors++; $display("FAIL b2b_rsp01: got %h %h want 0 11111111", rsp_t[0], rsp_t[1]); end
        checks++; if (rsp_t[2] !== 32'h0 || rsp_t[3] !== 32'h22222222) begin errors++; $display("FAIL b2b_rsp23: got %h %h want 0 22222222", rsp_t[2], rsp_t[3]); end
        checks++; if (ram[4] !== 32'h11111111 || ram[5] !== 32'h22222222) begin errors++; $display("FAIL b2b_ram: got %h %h want 11111111 22222222", ram[4], ram[5]); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
